// File: rtl/uart_resp_pkg.sv
// +--------------------------------------------------------------------+
// | uart_resp_pkg                                                      |
// | Opcodes, response codes and FSM states for uart_reg_responder.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_resp_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        GET_CSUM = 3'd3,
        RESP     = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_resp_regfile.sv
// +--------------------------------------------------------------------+
// | uart_resp_regfile                                                  |
// | 2**ADDR_W x 8 register file: one sync write port, async read port. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_resp_regfile #(
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [7:0]                 wdata_i,
    input  logic [ADDR_W-1:0]          raddr_i,
    output logic [7:0]                 rdata_o,
    output logic [8*(2**ADDR_W)-1:0]   regs_flat_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign regs_flat_o[8*g +: 8] = mem_q[g];
    end

endmodule

`default_nettype wire

// File: rtl/uart_reg_responder.sv
// +--------------------------------------------------------------------+
// | uart_reg_responder                                                 |
// | Parses 'W'/'R' byte frames into a register file, one reply/frame.  |
// | Option: UART_RESP_CSUM_EN adds a trailing XOR checksum byte.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_reg_responder
    import uart_resp_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [8*(2**ADDR_W)-1:0]   regs_flat,
    output logic                       err_timeout,
    output logic                       err_overrun
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_q,     state_d;
    logic               is_wr_q,     is_wr_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic               addr_ok_q,   addr_ok_d;
    logic [7:0]         tx_data_q,   tx_data_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_to_q,    err_to_d;
    logic               err_ov_q,    err_ov_d;
`ifdef UART_RESP_CSUM_EN
    logic [7:0]         csum_q,      csum_d;
    logic [7:0]         data_q,      data_d;
`endif

    logic               w_we;
    logic [7:0]         w_wdata;
    logic [ADDR_W-1:0]  w_raddr;
    logic [7:0]         w_rdata;
    logic               w_rx_in_range;
    logic               w_in_frame;

    assign w_rx_in_range = ((rx_data >> ADDR_W) == 8'd0);
    assign w_in_frame    = (state_q == GET_ADDR) || (state_q == GET_DATA) ||
                           (state_q == GET_CSUM);
    // The address byte itself is the read index when it arrives in GET_ADDR.
    assign w_raddr       = (state_q == GET_ADDR) ? rx_data[ADDR_W-1:0] : addr_q;

    uart_resp_regfile #(.ADDR_W(ADDR_W)) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .we_i        (w_we),
        .waddr_i     (addr_q),
        .wdata_i     (w_wdata),
        .raddr_i     (w_raddr),
        .rdata_o     (w_rdata),
        .regs_flat_o (regs_flat)
    );

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        addr_ok_d = addr_ok_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        err_to_d  = 1'b0;
        err_ov_d  = 1'b0;
        w_we      = 1'b0;
        w_wdata   = rx_data;
`ifdef UART_RESP_CSUM_EN
        csum_d    = csum_q;
        data_d    = data_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        is_wr_d = (rx_data == OP_WR);
                        state_d = GET_ADDR;
`ifdef UART_RESP_CSUM_EN
                        csum_d  = rx_data;
`endif
                    end else begin
                        tx_data_d = RSP_ERR;
                        state_d   = RESP;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    cnt_d     = '0;
                    addr_d    = rx_data[ADDR_W-1:0];
                    addr_ok_d = w_rx_in_range;
`ifdef UART_RESP_CSUM_EN
                    csum_d    = csum_q ^ rx_data;
                    state_d   = is_wr_q ? GET_DATA : GET_CSUM;
`else
                    if (is_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        tx_data_d = w_rx_in_range ? w_rdata : RSP_ERR;
                        state_d   = RESP;
                    end
`endif
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    cnt_d = '0;
`ifdef UART_RESP_CSUM_EN
                    data_d  = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = GET_CSUM;
`else
                    w_we      = addr_ok_q;
                    tx_data_d = addr_ok_q ? RSP_OK : RSP_ERR;
                    state_d   = RESP;
`endif
                end
            end
`ifdef UART_RESP_CSUM_EN
            GET_CSUM: begin
                if (rx_valid) begin
                    cnt_d   = '0;
                    state_d = RESP;
                    w_wdata = data_q;
                    if (rx_data != csum_q || !addr_ok_q) begin
                        tx_data_d = RSP_ERR;
                    end else if (is_wr_q) begin
                        w_we      = 1'b1;
                        tx_data_d = RSP_OK;
                    end else begin
                        tx_data_d = w_rdata;
                    end
                end
            end
`endif
            RESP: begin
                // A byte arriving here is lost, even on the handshake cycle.
                if (rx_valid) begin
                    err_ov_d = 1'b1;
                end
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_in_frame && !rx_valid) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                state_d  = IDLE;
                err_to_d = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            addr_ok_q <= 1'b0;
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
            err_to_q  <= 1'b0;
            err_ov_q  <= 1'b0;
`ifdef UART_RESP_CSUM_EN
            csum_q    <= 8'h00;
            data_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            addr_ok_q <= addr_ok_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            err_to_q  <= err_to_d;
            err_ov_q  <= err_ov_d;
`ifdef UART_RESP_CSUM_EN
            csum_q    <= csum_d;
            data_q    <= data_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = (state_q == RESP);
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
// +--------------------------------------------------------------------+
// | tb_uart_reg_responder                                              |
// | Directed vector table plus hand sequences for uart_reg_responder.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_reg_responder;

    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int NVEC        = 10;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] regs_flat;
    logic         err_timeout;
    logic         err_overrun;

    int checks = 0;
    int errors = 0;
    logic [127:0] model_regs;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] exp_tx;
        bit         wr;
        logic [3:0] wa;
        logic [7:0] wv;
    } vec_t;

    vec_t vecs [NVEC];

    uart_reg_responder #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .regs_flat   (regs_flat),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Multi-byte frames get their checksum appended when that option is built in.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int n);
        logic [7:0] cs;
        cs = b0;
        send_byte(b0);
        if (n > 1) begin send_byte(b1); cs = cs ^ b1; end
        if (n > 2) begin send_byte(b2); cs = cs ^ b2; end
`ifdef UART_RESP_CSUM_EN
        if (n > 1) send_byte(cs);
`endif
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({name, "_tx_valid_after_hs"}, {127'd0, tx_valid}, 128'd0);
    endtask

    task automatic expect_resp(input string name, input logic [7:0] exp);
        chk({name, "_tx_valid"}, {127'd0, tx_valid}, 128'd1);
        chk({name, "_tx_data"}, {120'd0, tx_data}, {120'd0, exp});
        chk({name, "_regs"}, regs_flat, model_regs);
    endtask

    initial begin
        int to_pulses;
        bit tx_seen;

        vecs[0] = '{8'h57, 8'h03, 8'hA5, 3, 8'h4B, 1'b1, 4'h3, 8'hA5};
        vecs[1] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 1'b0, 4'h0, 8'h00};
        vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h3F, 1'b0, 4'h0, 8'h00};
        vecs[3] = '{8'h52, 8'h10, 8'h00, 2, 8'h3F, 1'b0, 4'h0, 8'h00};
        vecs[4] = '{8'h57, 8'h10, 8'hFF, 3, 8'h3F, 1'b0, 4'h0, 8'h00};
        vecs[5] = '{8'h57, 8'h0F, 8'h3C, 3, 8'h4B, 1'b1, 4'hF, 8'h3C};
        vecs[6] = '{8'h52, 8'h0F, 8'h00, 2, 8'h3C, 1'b0, 4'h0, 8'h00};
        vecs[7] = '{8'h52, 8'h00, 8'h00, 2, 8'h00, 1'b0, 4'h0, 8'h00};
        vecs[8] = '{8'h57, 8'h00, 8'h81, 3, 8'h4B, 1'b1, 4'h0, 8'h81};
        vecs[9] = '{8'h52, 8'h80, 8'h00, 2, 8'h3F, 1'b0, 4'h0, 8'h00};

        model_regs = '0;
        rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx_valid", {127'd0, tx_valid}, 128'd0);
        chk("reset_tx_data", {120'd0, tx_data}, 128'd0);
        chk("reset_regs", regs_flat, 128'd0);
        chk("reset_errs", {126'd0, err_timeout, err_overrun}, 128'd0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n);
            if (vecs[i].wr) model_regs[8*vecs[i].wa +: 8] = vecs[i].wv;
            expect_resp($sformatf("vec%0d", i), vecs[i].exp_tx);
            handshake($sformatf("vec%0d", i));
        end

`ifdef UART_RESP_CSUM_EN
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h3C); send_byte(8'h6A);
        model_regs[8*1 +: 8] = 8'h3C;
        expect_resp("csum_good", 8'h4B);
        handshake("csum_good");
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h55); send_byte(8'h00);
        expect_resp("csum_bad", 8'h3F);
        handshake("csum_bad");
`endif

        // Abandon a write frame after its address byte.
        send_byte(8'h57); send_byte(8'h02);
        to_pulses = 0; tx_seen = 1'b0;
        for (int c = 0; c < TIMEOUT_CYC + 20; c++) begin
            @(negedge clk);
            if (err_timeout) to_pulses++;
            if (tx_valid) tx_seen = 1'b1;
        end
        chk("timeout_pulses", to_pulses, 1);
        chk("timeout_no_tx", {127'd0, tx_seen}, 128'd0);
        send_frame(8'h52, 8'h02, 8'h00, 2);
        expect_resp("after_timeout", 8'h00);
        handshake("after_timeout");

        // Backpressure with a byte arriving while the reply is pending.
        send_frame(8'h52, 8'h00, 8'h00, 2);
        expect_resp("bp_read", 8'h81);
        send_byte(8'h55);
        chk("overrun_pulse", {127'd0, err_overrun}, 128'd1);
        @(negedge clk);
        chk("overrun_single", {127'd0, err_overrun}, 128'd0);
        chk("bp_hold_valid", {127'd0, tx_valid}, 128'd1);
        chk("bp_hold_data", {120'd0, tx_data}, 128'h81);
        handshake("bp");

        // Opcode on the handshake cycle is dropped; next byte is a fresh opcode.
        send_frame(8'h41, 8'h00, 8'h00, 1);
        expect_resp("hs_pre", 8'h3F);
        @(negedge clk);
        tx_ready = 1'b1; rx_data = 8'h57; rx_valid = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0; rx_valid = 1'b0;
        chk("hs_overrun", {127'd0, err_overrun}, 128'd1);
        chk("hs_idle", {127'd0, tx_valid}, 128'd0);
        send_byte(8'h41);
        expect_resp("hs_next_opcode", 8'h3F);
        handshake("hs_next");

        // Reset in the middle of a frame.
        send_byte(8'h57); send_byte(8'h05);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_regs = '0;
        chk("rst_frame_tx_valid", {127'd0, tx_valid}, 128'd0);
        chk("rst_frame_regs", regs_flat, 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset while a response is pending.
        send_frame(8'h57, 8'h05, 8'h77, 3);
        model_regs[8*5 +: 8] = 8'h77;
        expect_resp("pre_rst_write", 8'h4B);
        #2;
        rst = 1'b0;
        #1;
        model_regs = '0;
        chk("rst_resp_tx_valid", {127'd0, tx_valid}, 128'd0);
        chk("rst_resp_regs", regs_flat, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h52, 8'h05, 8'h00, 2);
        expect_resp("after_rst", 8'h00);
        handshake("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder on the far side of the UART link: it consumes received bytes, parses register read/write command frames, and returns one response byte per frame through the transmit byte path. It holds a small 8-bit register file that a host drives over the serial line. It sits between the UART receiver byte output and the UART transmitter byte input, in the same clock domain.

## Interface
- ADDR_W, 4, register address width; the register file holds 2**ADDR_W bytes.
- TIMEOUT_CYC, 100000, clk cycles allowed between bytes of one frame before the frame is abandoned.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle pulse; rx_data valid this cycle.
- tx_data  output  8  response byte.
- tx_valid  output  1  response pending; held with tx_data stable until accepted.
- tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.
- regs_flat  output  8*2**ADDR_W  register file contents; byte i at [8i+7:8i].
- err_timeout  output  1  one-cycle pulse when a partial frame is abandoned.
- err_overrun  output  1  one-cycle pulse when rx_valid arrives while a response is pending.

## Operation
- Frames: write = 0x57 ('W'), addr, data; read = 0x52 ('R'), addr.
- Responses: write OK → 0x4B ('K'); read OK → regs[addr]; any error → 0x3F ('?').
- States: IDLE, GET_ADDR, GET_DATA, RESP.
- IDLE: on rx_valid, 'W' or 'R' → GET_ADDR (latch opcode); any other byte → RESP with '?'.
- GET_ADDR: on rx_valid latch addr. Write → GET_DATA. Read → RESP with regs[addr], or '?' if addr[7:ADDR_W] != 0.
- GET_DATA: on rx_valid, if addr in range, write regs[addr] <= rx_data and respond 'K'; otherwise respond '?' with no write. Either way → RESP.
- RESP: tx_valid=1. On tx_valid && tx_ready → IDLE, tx_valid=0.
- Timeout: counter cleared on every accepted byte, counts only in GET_ADDR/GET_DATA. Reaching TIMEOUT_CYC → IDLE, err_timeout pulse, no response, no write.
- rx_valid in RESP: byte dropped, err_overrun pulse, state unchanged.
- rx_valid in the same cycle as the tx handshake in RESP: treated as overrun and dropped (acceptance resumes the next cycle).
- Reset values: state IDLE, all regs 0x00, tx_data 0x00, tx_valid 0, err_timeout 0, err_overrun 0, timeout counter 0.
- Reset mid-frame or mid-response: everything clears immediately. A pending response is withdrawn and no partial write occurs.

## Timing
- Response latency: last frame byte at cycle N → tx_valid high at N+1. The register write also lands at N+1, so regs_flat shows the new value at N+1.
- Read data is sampled at cycle N.
- Back-to-back frames: the next opcode is accepted the cycle after the tx handshake.
- Timeout counter width: $clog2(TIMEOUT_CYC+1). The abandon fires on the cycle the count equals TIMEOUT_CYC.
- err_* are registered single-cycle pulses.

## Configuration
- UART_RESP_CSUM_EN defined: every frame carries a trailing checksum byte equal to the XOR of all preceding frame bytes.
  - A GET_CSUM state is added after GET_DATA (write) or GET_ADDR (read).
  - Writes commit only on a checksum match; a mismatch responds '?' with no write.
  - Latency is counted from the checksum byte.
- Not defined: no checksum byte; frames behave as in Operation.

## Structure
- Package uart_resp_pkg holds:
  - opcode constants OP_WR=8'h57 and OP_RD=8'h52;
  - response constants RSP_OK=8'h4B and RSP_ERR=8'h3F;
  - the state enum (IDLE, GET_ADDR, GET_DATA, GET_CSUM, RESP).
- Sub-module uart_resp_regfile holds:
  - a 2**ADDR_W x 8 array with asynchronous reset to 0;
  - one synchronous write port (we, waddr, wdata);
  - a combinational read port;
  - the flattened contents output.

## Test plan
- Write then read: rx 57,03,A5 → tx 4B and regs[3]=A5 at N+1; then rx 52,03 → tx A5.
- Bad opcode and range: rx 41 → tx 3F. rx 52,10 (ADDR_W=4) → tx 3F. rx 57,10,FF → tx 3F with regs unchanged.
- Timeout: rx 57,02, then idle TIMEOUT_CYC cycles → err_timeout pulse and no tx. A following 52,02 → tx 00.
- Backpressure/overrun: hold tx_ready=0 after 52,00 and send rx 55 → err_overrun pulse, tx_data stays 00 until tx_ready=1, then state returns to IDLE.
- Reset mid-frame and mid-response: rst=0 after 57,05 or while tx_valid=1 → tx_valid=0 immediately, regs all 00; after release, 52,05 → tx 00.
- With UART_RESP_CSUM_EN: rx 57,01,3C,6A → tx 4B, regs[1]=3C. rx 57,01,3C,00 → tx 3F, no write.
